// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a multi-cycle shift-add multiplier and
// restoring divider that commit into hi/lo. All state changes on the falling clock edge.
module ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] registerFileDataA,
  input  logic [31:0] registerFileDataB,
  input  logic [31:0] extendedSignal,
  input  logic [31:0] pcpp,
  input  logic        valid_in,
  input  logic        flush,
  input  logic        aluSrc,
  input  logic [3:0]  aluOp,
  input  logic [4:0]  writeReg_in,
  input  logic        regWrite_in,
  output logic [31:0] aluResult,
  output logic [31:0] storeData,
  output logic [31:0] pcppOut,
  output logic [4:0]  writeRegOut,
  output logic        regWriteOut,
  output logic        valid_out,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  iter_cnt;
  logic [31:0] work_hi, work_lo, operand_m;
  logic [31:0] operand_b, alu_comb;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic        is_muldiv, is_mult, accept_long, div_by_zero;

  assign operand_b   = aluSrc ? extendedSignal : registerFileDataB;
  assign is_mult     = (aluOp == 4'd12);
  assign is_muldiv   = is_mult || (aluOp == 4'd13);
  assign stall       = valid_in && is_muldiv && (state != DONE);
  assign accept_long = (state == IDLE) && valid_in && is_muldiv;
  assign div_by_zero = (aluOp == 4'd13) && (operand_b == 32'd0);

  // work_hi:work_lo holds the running product, or remainder:quotient for division.
  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_m} : 33'd0);
  assign div_shift = {work_hi, work_lo[31]};
  assign div_diff  = div_shift - {1'b0, operand_m};

  always_comb begin
    alu_comb = 32'd0;
    case (aluOp)
      4'd0:  alu_comb = registerFileDataA + operand_b;
      4'd1:  alu_comb = registerFileDataA - operand_b;
      4'd2:  alu_comb = registerFileDataA & operand_b;
      4'd3:  alu_comb = registerFileDataA | operand_b;
      4'd4:  alu_comb = registerFileDataA ^ operand_b;
      4'd5:  alu_comb = ~(registerFileDataA | operand_b);
      4'd6:  alu_comb = {31'd0, $signed(registerFileDataA) < $signed(operand_b)};
      4'd7:  alu_comb = {31'd0, registerFileDataA < operand_b};
      4'd8:  alu_comb = registerFileDataA << operand_b[4:0];
      4'd9:  alu_comb = registerFileDataA >> operand_b[4:0];
      4'd10: alu_comb = $unsigned($signed(registerFileDataA) >>> operand_b[4:0]);
      4'd11: alu_comb = {operand_b[15:0], 16'h0000};
      4'd14: alu_comb = hi;
      4'd15: alu_comb = lo;
      default: alu_comb = 32'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (accept_long) state_next = is_mult ? MUL : (div_by_zero ? DONE : DIV);
        MUL:  if (iter_cnt == 5'd31) state_next = DONE;
        DIV:  if (iter_cnt == 5'd31) state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Iteration datapath and hi/lo commit; only latched operands are used once busy.
  always_ff @(negedge clock) begin
    if (reset) begin
      iter_cnt  <= 5'd0;
      work_hi   <= 32'd0;
      work_lo   <= 32'd0;
      operand_m <= 32'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        IDLE: if (accept_long && !flush) begin
          operand_m <= is_mult ? registerFileDataA : operand_b;
          work_hi   <= div_by_zero ? registerFileDataA : 32'd0;
          work_lo   <= is_mult ? operand_b : (div_by_zero ? 32'hFFFF_FFFF : registerFileDataA);
          iter_cnt  <= 5'd0;
        end
        MUL: begin
          {work_hi, work_lo} <= {mul_sum, work_lo[31:1]};
          iter_cnt <= iter_cnt + 5'd1;
        end
        DIV: begin
          work_hi  <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
          work_lo  <= {work_lo[30:0], ~div_diff[32]};
          iter_cnt <= iter_cnt + 5'd1;
        end
        DONE: if (!flush) begin
          hi <= work_hi;
          lo <= work_lo;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      aluResult   <= 32'd0;
      storeData   <= 32'd0;
      pcppOut     <= 32'd0;
      writeRegOut <= 5'd0;
      regWriteOut <= 1'b0;
      valid_out   <= 1'b0;
    end else if (flush) begin
      regWriteOut <= 1'b0;
      valid_out   <= 1'b0;
    end else if (state == DONE) begin
      aluResult   <= work_lo;
      regWriteOut <= 1'b0;
      valid_out   <= 1'b1;
    end else if (state == IDLE && valid_in && !is_muldiv) begin
      aluResult   <= alu_comb;
      storeData   <= registerFileDataB;
      pcppOut     <= pcpp;
      writeRegOut <= writeReg_in;
      regWriteOut <= regWrite_in;
      valid_out   <= 1'b1;
    end else begin
      regWriteOut <= 1'b0;
      valid_out   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for single-cycle ops, hand sequences
// for multiply/divide timing, reset and flush behaviour.
module tb_ex_stage;

  logic        clock, reset;
  logic [31:0] registerFileDataA, registerFileDataB, extendedSignal, pcpp;
  logic        valid_in, flush, aluSrc;
  logic [3:0]  aluOp;
  logic [4:0]  writeReg_in;
  logic        regWrite_in;
  logic [31:0] aluResult, storeData, pcppOut, hi, lo;
  logic [4:0]  writeRegOut;
  logic        regWriteOut, valid_out, stall;

  int checks_total = 0;
  int checks_passed = 0;

  ex_stage dut (
    .clock(clock), .reset(reset),
    .registerFileDataA(registerFileDataA), .registerFileDataB(registerFileDataB),
    .extendedSignal(extendedSignal), .pcpp(pcpp),
    .valid_in(valid_in), .flush(flush), .aluSrc(aluSrc), .aluOp(aluOp),
    .writeReg_in(writeReg_in), .regWrite_in(regWrite_in),
    .aluResult(aluResult), .storeData(storeData), .pcppOut(pcppOut),
    .writeRegOut(writeRegOut), .regWriteOut(regWriteOut), .valid_out(valid_out),
    .stall(stall), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ext;
    logic        src;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ext, input logic src, input logic vin);
    aluOp             = op;
    registerFileDataA = a;
    registerFileDataB = b;
    extendedSignal    = ext;
    aluSrc            = src;
    valid_in          = vin;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  initial begin
    int n;
    int vo_seen;

    vecs[0]  = '{4'd0,  32'd5,          32'd7,          32'd0,      1'b0, 32'd12};
    vecs[1]  = '{4'd1,  32'd5,          32'd7,          32'd0,      1'b0, 32'hFFFF_FFFE};
    vecs[2]  = '{4'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,      1'b0, 32'h00F0_00F0};
    vecs[3]  = '{4'd3,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,      1'b0, 32'hFFF0_FFF0};
    vecs[4]  = '{4'd4,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'd0,      1'b0, 32'hFF00_FF00};
    vecs[5]  = '{4'd5,  32'd0,          32'd0,          32'd0,      1'b0, 32'hFFFF_FFFF};
    vecs[6]  = '{4'd6,  32'hFFFF_FFFE,  32'd1,          32'd0,      1'b0, 32'd1};
    vecs[7]  = '{4'd7,  32'hFFFF_FFFE,  32'd1,          32'd0,      1'b0, 32'd0};
    vecs[8]  = '{4'd8,  32'd1,          32'd31,         32'd0,      1'b0, 32'h8000_0000};
    vecs[9]  = '{4'd9,  32'h8000_0000,  32'd4,          32'd0,      1'b0, 32'h0800_0000};
    vecs[10] = '{4'd10, 32'h8000_0000,  32'd4,          32'd0,      1'b0, 32'hF800_0000};
    vecs[11] = '{4'd11, 32'd0,          32'd99,         32'h0000_1234, 1'b1, 32'h1234_0000};

    reset = 1'b1; flush = 1'b0; writeReg_in = 5'd0; regWrite_in = 1'b0; pcpp = 32'd0;
    applyStimulus(4'd12, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset aluResult", aluResult, 32'd0);
    checkOutput("reset valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("reset hi", hi, 32'd0);
    checkOutput("reset lo", lo, 32'd0);
    checkOutput("reset stall idle", {31'd0, stall}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      writeReg_in = i[4:0];
      regWrite_in = 1'b1;
      pcpp        = i * 4;
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ext, vecs[i].src, 1'b1);
      tick();
      checkOutput($sformatf("vec%0d aluResult", i), aluResult, vecs[i].expected);
      checkOutput($sformatf("vec%0d valid_out", i), {31'd0, valid_out}, 32'd1);
      checkOutput($sformatf("vec%0d storeData", i), storeData, vecs[i].b);
      checkOutput($sformatf("vec%0d writeRegOut", i), {27'd0, writeRegOut}, i);
      checkOutput($sformatf("vec%0d pcppOut", i), pcppOut, i * 4);
    end

    // Immediate operand path: 10 + (-1) = 9
    applyStimulus(4'd0, 32'd10, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b1);
    tick();
    checkOutput("addi aluResult", aluResult, 32'd9);

    applyStimulus(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    tick();
    checkOutput("bubble valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("bubble regWriteOut", {31'd0, regWriteOut}, 32'd0);

    // MULTU 0xFFFFFFFF x 2: stall for exactly 33 cycles, retire on the 34th edge
    regWrite_in = 1'b1;
    applyStimulus(4'd12, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1);
    n = 0; vo_seen = 0;
    while (stall === 1'b1 && n < 100) begin
      tick();
      n++;
      if (valid_out === 1'b1) vo_seen++;
    end
    checkOutput("multu stall cycles", n, 33);
    checkOutput("multu busy valid_out", vo_seen, 0);
    tick();
    checkOutput("multu hi", hi, 32'h0000_0001);
    checkOutput("multu lo", lo, 32'hFFFF_FFFE);
    checkOutput("multu valid_out", {31'd0, valid_out}, 32'd1);
    checkOutput("multu regWriteOut", {31'd0, regWriteOut}, 32'd0);
    checkOutput("multu aluResult", aluResult, 32'hFFFF_FFFE);
    applyStimulus(4'd14, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    checkOutput("mfhi after multu", aluResult, 32'd1);
    applyStimulus(4'd15, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    checkOutput("mflo after multu", aluResult, 32'hFFFF_FFFE);

    applyStimulus(4'd13, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
    repeat (33) tick();
    checkOutput("divu stall in done", {31'd0, stall}, 32'd0);
    checkOutput("divu pre-retire valid_out", {31'd0, valid_out}, 32'd0);
    tick();
    checkOutput("divu hi", hi, 32'd2);
    checkOutput("divu lo", lo, 32'd14);
    checkOutput("divu valid_out", {31'd0, valid_out}, 32'd1);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    applyStimulus(4'd13, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1);
    tick();
    checkOutput("divu0 stall after accept", {31'd0, stall}, 32'd0);
    tick();
    checkOutput("divu0 hi", hi, 32'd9);
    checkOutput("divu0 lo", lo, 32'hFFFF_FFFF);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Reset during MUL iteration 10 abandons the operation
    applyStimulus(4'd12, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1);
    repeat (11) tick();
    reset = 1'b1;
    tick();
    checkOutput("reset mid-mul hi", hi, 32'd0);
    checkOutput("reset mid-mul lo", lo, 32'd0);
    checkOutput("reset mid-mul valid_out", {31'd0, valid_out}, 32'd0);
    reset = 1'b0;
    applyStimulus(4'd12, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    checkOutput("reset mid-mul stall", {31'd0, stall}, 32'd0);
    repeat (40) tick();
    checkOutput("reset mid-mul lo stays", lo, 32'd0);

    applyStimulus(4'd12, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1);
    repeat (34) tick();
    checkOutput("multu 3x5 lo", lo, 32'd15);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();

    // Flush during DIV iteration 5 drops the divide without touching hi/lo
    applyStimulus(4'd13, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    checkOutput("flush div valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("flush div hi", hi, 32'd0);
    checkOutput("flush div lo", lo, 32'd15);
    flush = 1'b0;
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (40) tick();
    checkOutput("flush div hi later", hi, 32'd0);
    checkOutput("flush div lo later", lo, 32'd15);

    applyStimulus(4'd0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    checkOutput("flush add valid_out", {31'd0, valid_out}, 32'd0);
    checkOutput("flush add regWriteOut", {31'd0, regWriteOut}, 32'd0);
    flush = 1'b0;

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clock, input, 1 bit; single clock; all state updates on the falling edge of clock.
REQ-002 SHALL have port reset, input, 1 bit; synchronous, active-high, sampled on the falling edge of clock.
REQ-003 SHALL have inputs registerFileDataA, registerFileDataB, extendedSignal, pcpp, each 32 bits, driven by the ID/EX register.
REQ-004 SHALL have inputs valid_in (1), flush (1), aluSrc (1; 1 selects extendedSignal as operand B), aluOp (4), writeReg_in (5), regWrite_in (1).
REQ-005 SHALL have outputs aluResult (32), storeData (32), pcppOut (32), writeRegOut (5), regWriteOut (1), valid_out (1); all registered.
REQ-006 SHALL have output stall (1, combinational); upstream holds all inputs while stall=1.
REQ-007 SHALL have outputs hi, lo (32 each, registered).

Function
REQ-008 Operand B SHALL be extendedSignal when aluSrc=1, else registerFileDataB; operand A SHALL be registerFileDataA.
REQ-009 aluOp encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 MULTU, 13 DIVU, 14 MFHI, 15 MFLO.
REQ-010 ADD/SUB SHALL be 32-bit wrap-around, no overflow trap; SLT/SLTU SHALL yield 1 or 0 zero-extended.
REQ-011 Shifts SHALL shift operand A by operand B[4:0]; LUI SHALL yield {B[15:0],16'h0}.
REQ-012 Single-cycle ops (0-11, 14, 15): on an edge with valid_in=1 and stall=0, output register SHALL load result, storeData=registerFileDataB, pcppOut=pcpp, writeRegOut=writeReg_in, regWriteOut=regWrite_in, valid_out=1.
REQ-013 On an edge with valid_in=0, valid_out SHALL be 0 and regWriteOut SHALL be 0.
REQ-014 MULTU/DIVU SHALL use a multi-cycle FSM with states IDLE, MUL, DIV, DONE and a 5-bit iteration counter.
REQ-015 stall SHALL equal valid_in AND (aluOp is MULTU or DIVU) AND state != DONE.
REQ-016 IDLE -> MUL/DIV on the accepting edge: operands latched, counter=0; valid_out=0 on that edge and every iteration edge.
REQ-017 MUL SHALL perform 32 shift-add iterations (one per edge) forming a 64-bit unsigned product; after iteration 32 state SHALL be DONE.
REQ-018 DIV SHALL perform 32 restoring-division iterations forming a 32-bit quotient and remainder; after iteration 32 state SHALL be DONE.
REQ-019 DIVU with operand B = 0 SHALL go IDLE -> DONE directly, result quotient 0xFFFFFFFF, remainder = operand A.
REQ-020 DONE -> IDLE on the next edge: hi/lo written (MULTU: hi=product[63:32], lo=product[31:0]; DIVU: hi=remainder, lo=quotient), valid_out=1, regWriteOut=0, aluResult=lo value.
REQ-021 Total MULTU/DIVU occupancy SHALL be 34 edges (accept + 32 iterations + retire), stall high for the first 33 cycles.
REQ-022 MFHI/MFLO SHALL read hi/lo as committed; an MFHI directly after a MULTU SHALL see the new value.
REQ-023 flush=1 at an edge SHALL force valid_out=0, regWriteOut=0, FSM to IDLE; hi/lo unchanged; flush overrides valid_in.
REQ-024 aluOp changes while state != IDLE SHALL be ignored; the FSM uses latched operands only.

Reset
REQ-025 reset=1 at an edge SHALL clear all outputs, hi, lo, counter to 0 and state to IDLE, overriding flush and any in-flight operation.
REQ-026 After reset, stall SHALL depend only on valid_in and aluOp per REQ-015.

Verification
REQ-027 ADD A=5, B=7, aluSrc=0 -> next edge aluResult=12, valid_out=1.
REQ-028 A=0xFFFFFFFE, B=1: SLT -> 1; SLTU -> 0; SRA by B=4 with A=0x80000000 -> 0xF8000000.
REQ-029 MULTU 0xFFFFFFFF x 2 -> stall high exactly 33 cycles; then hi=0x00000001, lo=0xFFFFFFFE; following MFHI -> 1.
REQ-030 DIVU 100/7 -> hi=2, lo=14 after 34 edges; DIVU 9/0 -> hi=9, lo=0xFFFFFFFF after 2 edges.
REQ-031 reset asserted at MUL iteration 10 -> next edge state IDLE, hi=lo=0, valid_out=0; stall=0 once valid_in deasserted.
REQ-032 flush during DIV iteration 5 -> FSM IDLE, hi/lo keep prior values, valid_out=0.
